ula_controle: RTL and testbench

- Sequential control/accumulator stage wrapped around the 8-bit ULA (ula_bits).
- Accepts commands over a valid/ready handshake and drives the ULA operands and seletor from registered state.
- Captures resultado/carry_out into an accumulator and carry/zero flags, then returns the result over a valid/ready response handshake.
- Feeds the ULA combinationally and consumes its outputs one cycle later; the ULA sits directly between this block's drive and capture ports.

---
 rtl/ula_controle.sv | 141 ++++++++++++++
 tb/tb_ula_controle.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_controle.sv
// Sequential control/accumulator stage around the 8-bit ULA (ula_bits).
// Accepts a command, drives the ULA from registered state for one cycle,
// captures the result into the accumulator and flags, then offers a response.
module ula_controle #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Command channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_operand,
    input  logic                 cmd_use_carry,
    // ULA drive
    output logic [WIDTH-1:0]     ula_a,
    output logic [WIDTH-1:0]     ula_b,
    output logic                 ula_carry_in,
    output logic [2:0]           ula_seletor,
    // ULA capture
    input  logic [WIDTH-1:0]     ula_resultado,
    input  logic                 ula_carry_out,
    // Response channel
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 resp_carry,
    output logic                 resp_zero,
    output logic                 resp_err,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    localparam logic [3:0] OpLoad  = 4'b1000;
    localparam logic [3:0] OpClear = 4'b1001;

    state_t               state_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [3:0]           op_q;
    logic                 use_carry_q;
    logic                 carry_q;
    logic                 zero_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 cmd_ready_q;
    logic                 resp_valid_q;

    // Control FSM, datapath capture and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            opnd_q       <= '0;
            op_q         <= '0;
            use_carry_q  <= 1'b0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b1;
            err_q        <= 1'b0;
            count_q      <= '0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        opnd_q      <= cmd_operand;
                        use_carry_q <= cmd_use_carry;
                        cmd_ready_q <= 1'b0;
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    if (!op_q[3]) begin
                        acc_q   <= ula_resultado;
                        // Only the arithmetic seletors (100/101) produce a carry
                        carry_q <= (op_q[2:1] == 2'b10) ? ula_carry_out : 1'b0;
                        err_q   <= 1'b0;
                        zero_q  <= (ula_resultado == '0);
                    end else if (op_q == OpLoad) begin
                        acc_q   <= opnd_q;
                        carry_q <= 1'b0;
                        err_q   <= 1'b0;
                        zero_q  <= (opnd_q == '0);
                    end else if (op_q == OpClear) begin
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        err_q   <= 1'b0;
                        zero_q  <= 1'b1;
                    end else begin
                        // Illegal opcode: keep acc and carry, flag the error
                        err_q  <= 1'b1;
                        zero_q <= (acc_q == '0);
                    end
                    resp_valid_q <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        count_q      <= count_q + 1'b1;
                        resp_valid_q <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    resp_valid_q <= 1'b0;
                    cmd_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // ULA is fed purely from registered state
    always_comb begin
        ula_a        = acc_q;
        ula_b        = opnd_q;
        ula_seletor  = op_q[2:0];
        ula_carry_in = use_carry_q & carry_q;
    end

    // Response and handshake outputs mirror the registers
    always_comb begin
        cmd_ready  = cmd_ready_q;
        resp_valid = resp_valid_q;
        resp_data  = acc_q;
        resp_carry = carry_q;
        resp_zero  = zero_q;
        resp_err   = err_q;
        op_count   = count_q;
    end

endmodule

// File: tb/tb_ula_controle.sv
// Self-checking bench for ula_controle with a behavioural ULA in the loop.
module tb_ula_controle;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       cmd_use_carry;
    logic [7:0] ula_a;
    logic [7:0] ula_b;
    logic       ula_carry_in;
    logic [2:0] ula_seletor;
    logic [7:0] ula_resultado;
    logic       ula_carry_out;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_carry;
    logic       resp_zero;
    logic       resp_err;
    logic [7:0] op_count;

    int errors;
    int checks;
    logic [7:0] exp_cnt;

    ula_controle #(
        .WIDTH    (8),
        .CNT_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_operand  (cmd_operand),
        .cmd_use_carry(cmd_use_carry),
        .ula_a        (ula_a),
        .ula_b        (ula_b),
        .ula_carry_in (ula_carry_in),
        .ula_seletor  (ula_seletor),
        .ula_resultado(ula_resultado),
        .ula_carry_out(ula_carry_out),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_carry   (resp_carry),
        .resp_zero    (resp_zero),
        .resp_err     (resp_err),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA: 000 AND, 001 OR, 010 NOT A, 011 NAND, 100 ADD, 101 A+~B+cin, else 0
    always_comb begin
        logic [8:0] sum;
        sum           = 9'd0;
        ula_resultado = 8'h00;
        ula_carry_out = 1'b0;
        case (ula_seletor)
            3'b000: ula_resultado = ula_a & ula_b;
            3'b001: ula_resultado = ula_a | ula_b;
            3'b010: ula_resultado = ~ula_a;
            3'b011: ula_resultado = ~(ula_a & ula_b);
            3'b100: begin
                sum = {1'b0, ula_a} + {1'b0, ula_b} + {8'd0, ula_carry_in};
                ula_resultado = sum[7:0];
                ula_carry_out = sum[8];
            end
            3'b101: begin
                sum = {1'b0, ula_a} + {1'b0, ~ula_b} + {8'd0, ula_carry_in};
                ula_resultado = sum[7:0];
                ula_carry_out = sum[8];
            end
            default: begin
                ula_resultado = 8'h00;
                ula_carry_out = 1'b0;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full command/response with fixed latency and immediate acceptance
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] opnd, input logic uc,
                          input logic [7:0] e_data, input logic e_c, input logic e_z,
                          input logic e_e, input string name);
        @(negedge clk);
        cmd_op        = op;
        cmd_operand   = opnd;
        cmd_use_carry = uc;
        cmd_valid     = 1'b1;
        chk({name, " cmd_ready idle"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk({name, " resp_valid in exec"}, {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({name, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, " data"}, {24'd0, resp_data}, {24'd0, e_data});
        chk({name, " carry"}, {31'd0, resp_carry}, {31'd0, e_c});
        chk({name, " zero"}, {31'd0, resp_zero}, {31'd0, e_z});
        chk({name, " err"}, {31'd0, resp_err}, {31'd0, e_e});
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk({name, " op_count"}, {24'd0, op_count}, {24'd0, exp_cnt});
        chk({name, " back to idle"}, {30'd0, resp_valid, cmd_ready}, 32'd1);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] opnd;
        logic       uc;
        logic [7:0] data;
        logic       c;
        logic       z;
        logic       e;
        string      name;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] opnd, input logic uc,
                                input logic [7:0] data, input logic c, input logic z,
                                input logic e, input string name);
        vec_t v;
        v.op = op; v.opnd = opnd; v.uc = uc; v.data = data;
        v.c = c; v.z = z; v.e = e; v.name = name;
        return v;
    endfunction

    initial begin
        logic [7:0] held;
        errors        = 0;
        checks        = 0;
        exp_cnt       = 8'd0;
        cmd_valid     = 1'b0;
        cmd_op        = 4'd0;
        cmd_operand   = 8'd0;
        cmd_use_carry = 1'b0;
        resp_ready    = 1'b0;
        rst_n         = 1'b0;

        vecs[0]  = mk(4'b1000, 8'hAA, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, "load_aa");
        vecs[1]  = mk(4'b0000, 8'hCC, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0, "and");
        vecs[2]  = mk(4'b1000, 8'hAA, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, "reload1");
        vecs[3]  = mk(4'b0001, 8'hCC, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, "or");
        vecs[4]  = mk(4'b1000, 8'hAA, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, "reload2");
        vecs[5]  = mk(4'b0010, 8'h00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, "not");
        vecs[6]  = mk(4'b1000, 8'hAA, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, "reload3");
        vecs[7]  = mk(4'b0011, 8'hCC, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, "nand");
        vecs[8]  = mk(4'b1000, 8'h1B, 1'b0, 8'h1B, 1'b0, 1'b0, 1'b0, "load_1b");
        vecs[9]  = mk(4'b0100, 8'h15, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "add_nc");
        vecs[10] = mk(4'b1000, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, "load_ff");
        vecs[11] = mk(4'b0100, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "add_ovf");
        vecs[12] = mk(4'b0100, 8'h30, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, "add_chain");
        vecs[13] = mk(4'b1000, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, "load_ff2");
        vecs[14] = mk(4'b0100, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "add_ovf2");
        vecs[15] = mk(4'b1111, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "illegal");
        vecs[16] = mk(4'b1000, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, "load_5a");
        vecs[17] = mk(4'b0111, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "sel111");
        vecs[18] = mk(4'b1000, 8'h1B, 1'b0, 8'h1B, 1'b0, 1'b0, 1'b0, "load_1b2");
        vecs[19] = mk(4'b0100, 8'h15, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, "add_c_after_load");
        vecs[20] = mk(4'b1001, 8'h99, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "clear");

        // Reset state
        #12;
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst op_count", {24'd0, op_count}, 32'd0);
        chk("rst resp_zero", {31'd0, resp_zero}, 32'd1);
        chk("rst ula drive", {12'd0, ula_a, ula_b, ula_carry_in, ula_seletor}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            do_cmd(vecs[i].op, vecs[i].opnd, vecs[i].uc, vecs[i].data,
                   vecs[i].c, vecs[i].z, vecs[i].e, vecs[i].name);
        end

        // Early resp_ready is ignored until the response is actually offered
        @(negedge clk);
        cmd_op = 4'b1000; cmd_operand = 8'h3C; cmd_use_carry = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("early ready no count", {24'd0, op_count}, {24'd0, exp_cnt});
        chk("early ready resp_valid", {31'd0, resp_valid}, 32'd1);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("early ready count", {24'd0, op_count}, {24'd0, exp_cnt});

        // Backpressure: response held for 5 cycles while another command waits
        @(negedge clk);
        cmd_op = 4'b1000; cmd_operand = 8'hC3; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_op = 4'b1000; cmd_operand = 8'h11;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp data stable", {24'd0, resp_data}, 32'h0000_00C3);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("bp count", {24'd0, op_count}, {24'd0, exp_cnt});
        @(negedge clk);
        chk("bp second cmd not taken", {24'd0, resp_data}, 32'h0000_00C3);
        chk("bp idle", {30'd0, resp_valid, cmd_ready}, 32'd1);

        // Abort: reset asserted while in EXEC
        @(negedge clk);
        cmd_op = 4'b1000; cmd_operand = 8'h42; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort op_count", {24'd0, op_count}, 32'd0);
        chk("abort flags", {29'd0, resp_zero, resp_carry, resp_err}, 32'd4);
        chk("abort data", {24'd0, resp_data}, 32'd0);
        chk("abort ula drive", {12'd0, ula_a, ula_b, ula_carry_in, ula_seletor}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        @(negedge clk);
        held = resp_data;
        chk("abort cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort no resp", {23'd0, resp_valid, held}, 32'd0);

        // Counter wrap through 256 CLEARs
        for (int i = 0; i < 256; i++) begin
            do_cmd(4'b1001, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "wrap_clear");
        end
        chk("wrap op_count", {24'd0, op_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
